// File: rtl/mcy_pkg.sv
// Shared types for the MCY mutant sequencer: FSM state encoding, default
// widths and the per-mutant result record.
package mcy_pkg;

    localparam int MCY_MUTSEL_W = 8;
    localparam int MCY_WINDOW_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SELECT,
        ST_SETTLE,
        ST_RUN,
        ST_REPORT,
        ST_FINISH
    } mcy_seq_state_e;

    // Result record; field widths follow the package defaults, so a top
    // instance overriding MUTSEL_W/WINDOW_W needs matching package values.
    typedef struct packed {
        logic [MCY_MUTSEL_W-1:0] idx;
        logic                    detected;
        logic [MCY_WINDOW_W-1:0] cycles;
    } mcy_result_t;

endpackage

// File: rtl/mcy_sig_compare.sv
// Purely combinational signature comparator: gates the compare-valid strobe
// with the sequencer's run window and XOR-reduces the two signatures.
module mcy_sig_compare
#(
    parameter int SIG_W = 128
)
(
    input  logic             enable,
    input  logic             cmp_valid,
    input  logic [SIG_W-1:0] sig_golden,
    input  logic [SIG_W-1:0] sig_mutant,
    output logic             count_en,
    output logic             mismatch
);

    // Valid compare cycles inside the window, and mismatches among them
    always_comb begin
        count_en = enable && cmp_valid;
        mismatch = count_en && (|(sig_golden ^ sig_mutant));
    end

endmodule

// File: rtl/mcy_mutant_sequencer.sv
// Mutation-coverage sequencer: walks the mutant selector over a programmed
// index range, observes each mutant for a window of valid compare cycles and
// reports detection per mutant over a valid/ready result channel.
module mcy_mutant_sequencer
    import mcy_pkg::*;
#(
    parameter int MUTSEL_W      = MCY_MUTSEL_W,
    parameter int SIG_W         = 128,
    parameter int WINDOW_W      = MCY_WINDOW_W,
    parameter int SETTLE_CYCLES = 2,
    parameter int EARLY_EXIT    = 1
)
(
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                start_i,
    input  logic                abort_i,
    input  logic [MUTSEL_W-1:0] first_idx_i,
    input  logic [MUTSEL_W-1:0] last_idx_i,
    input  logic [WINDOW_W-1:0] window_i,
    input  logic                cmp_valid_i,
    input  logic [SIG_W-1:0]    sig_golden_i,
    input  logic [SIG_W-1:0]    sig_mutant_i,
    output logic [MUTSEL_W-1:0] mutsel_o,
    output logic                busy_o,
    output logic                done_o,
    output logic                result_valid_o,
    input  logic                result_ready_i,
    output logic [MUTSEL_W-1:0] result_idx_o,
    output logic                result_detected_o,
    output logic [WINDOW_W-1:0] result_cycles_o,
    output logic [MUTSEL_W:0]   detect_count_o
);

    localparam int DCNT_W = MUTSEL_W + 1;
    localparam logic [3:0] SETTLE_LAST =
        4'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

    mcy_seq_state_e      state_q;
    mcy_seq_state_e      state_d;

    logic [MUTSEL_W-1:0] idx_q;
    logic [MUTSEL_W-1:0] last_q;
    logic [WINDOW_W-1:0] window_q;
    logic [MUTSEL_W-1:0] mutsel_q;
    logic [WINDOW_W-1:0] win_cnt_q;
    logic [WINDOW_W-1:0] win_inc;
    logic [3:0]          settle_cnt_q;
    logic                mism_flag_q;
    logic [DCNT_W-1:0]   detect_cnt_q;
    mcy_result_t         result_q;

    logic                count_en;
    logic                mismatch;
    logic                run_done;
    logic                start_bad;
    logic                abort_take;
    logic                handshake;

    mcy_sig_compare #(
        .SIG_W (SIG_W)
    ) u_cmp (
        .enable     (state_q == ST_RUN),
        .cmp_valid  (cmp_valid_i),
        .sig_golden (sig_golden_i),
        .sig_mutant (sig_mutant_i),
        .count_en   (count_en),
        .mismatch   (mismatch)
    );

    // Window bookkeeping, abort qualification and handshake detection
    always_comb begin
        win_inc    = win_cnt_q + WINDOW_W'(1);
        run_done   = (count_en && (win_inc == window_q)) ||
                     ((EARLY_EXIT != 0) && mismatch);
        start_bad  = (first_idx_i > last_idx_i) || (first_idx_i == '0) ||
                     (window_i == '0);
        abort_take = abort_i && (state_q != ST_IDLE) && (state_q != ST_FINISH);
        handshake  = (state_q == ST_REPORT) && !abort_i && result_ready_i;
    end

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort overrides every transition outside IDLE/FINISH
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = start_bad ? ST_FINISH : ST_SELECT;
                end
            end
            ST_SELECT: begin
                state_d = (SETTLE_CYCLES == 0) ? ST_RUN : ST_SETTLE;
            end
            ST_SETTLE: begin
                if (settle_cnt_q == SETTLE_LAST) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (run_done) begin
                    state_d = ST_REPORT;
                end
            end
            ST_REPORT: begin
                if (result_ready_i) begin
                    state_d = (idx_q == last_q) ? ST_FINISH : ST_SELECT;
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (abort_take) begin
            state_d = ST_FINISH;
        end
    end

    // Output decode from state; an abort withdraws a pending result at once
    always_comb begin
        busy_o         = (state_q != ST_IDLE) && (state_q != ST_FINISH);
        done_o         = (state_q == ST_FINISH);
        result_valid_o = (state_q == ST_REPORT) && !abort_i;
    end

    // Campaign datapath: range latch, selector, window counter, results
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            idx_q        <= '0;
            last_q       <= '0;
            window_q     <= '0;
            mutsel_q     <= '0;
            win_cnt_q    <= '0;
            settle_cnt_q <= '0;
            mism_flag_q  <= 1'b0;
            detect_cnt_q <= '0;
            result_q     <= '0;
        end else if (!abort_take) begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        idx_q        <= first_idx_i;
                        last_q       <= last_idx_i;
                        window_q     <= window_i;
                        detect_cnt_q <= '0;
                    end
                end
                ST_SELECT: begin
                    mutsel_q     <= idx_q;
                    win_cnt_q    <= '0;
                    settle_cnt_q <= '0;
                    mism_flag_q  <= 1'b0;
                end
                ST_SETTLE: begin
                    settle_cnt_q <= settle_cnt_q + 4'd1;
                end
                ST_RUN: begin
                    if (count_en) begin
                        win_cnt_q <= win_inc;
                    end
                    if (mismatch) begin
                        mism_flag_q <= 1'b1;
                    end
                    // run_done implies a valid cycle, so win_inc is the final count
                    if (run_done) begin
                        result_q.idx      <= idx_q;
                        result_q.detected <= mism_flag_q || mismatch;
                        result_q.cycles   <= win_inc;
                    end
                end
                ST_REPORT: begin
                    if (handshake) begin
                        if (result_q.detected) begin
                            detect_cnt_q <= detect_cnt_q + DCNT_W'(1);
                        end
                        // Increment only when not at last: no wrap at the top index
                        if (idx_q != last_q) begin
                            idx_q <= idx_q + MUTSEL_W'(1);
                        end
                    end
                end
                ST_FINISH: begin
                    mutsel_q <= '0;
                end
                default: begin
                    mutsel_q <= '0;
                end
            endcase
        end
    end

    assign mutsel_o          = mutsel_q;
    assign result_idx_o      = result_q.idx;
    assign result_detected_o = result_q.detected;
    assign result_cycles_o   = result_q.cycles;
    assign detect_count_o    = detect_cnt_q;

endmodule

// File: tb/tb_mcy_mutant_sequencer.sv
// Directed bench for mcy_mutant_sequencer. Two instances share stimulus:
// dut_a with early exit, dut_b running the full window.
module tb_mcy_mutant_sequencer;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         abort;
    logic [7:0]   first;
    logic [7:0]   last;
    logic [15:0]  window;
    logic         cmp_valid;
    logic [127:0] sig_gold;
    logic [127:0] sig_mut;
    logic         ready;

    logic [7:0]   mutsel_a, mutsel_b;
    logic         busy_a, busy_b;
    logic         done_a, done_b;
    logic         rv_a, rv_b;
    logic [7:0]   ridx_a, ridx_b;
    logic         rdet_a, rdet_b;
    logic [15:0]  rcyc_a, rcyc_b;
    logic [8:0]   dcnt_a, dcnt_b;

    localparam logic [127:0] GOLD = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
    localparam logic [127:0] FLIP = 128'h0000_0000_0000_2000_0000_0000_0000_0000;

    typedef struct {
        logic [7:0]  idx;
        logic        det;
        logic [15:0] cyc;
        int unsigned at;
    } rec_t;

    rec_t        qa[$];
    rec_t        qb[$];
    int unsigned da[$];
    int unsigned db[$];
    int unsigned cyc = 0;
    int unsigned base;
    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mcy_mutant_sequencer #(
        .MUTSEL_W (8), .SIG_W (128), .WINDOW_W (16),
        .SETTLE_CYCLES (2), .EARLY_EXIT (1)
    ) dut_a (
        .clk_i (clk), .rst_i (rst), .start_i (start), .abort_i (abort),
        .first_idx_i (first), .last_idx_i (last), .window_i (window),
        .cmp_valid_i (cmp_valid), .sig_golden_i (sig_gold), .sig_mutant_i (sig_mut),
        .mutsel_o (mutsel_a), .busy_o (busy_a), .done_o (done_a),
        .result_valid_o (rv_a), .result_ready_i (ready),
        .result_idx_o (ridx_a), .result_detected_o (rdet_a),
        .result_cycles_o (rcyc_a), .detect_count_o (dcnt_a)
    );

    mcy_mutant_sequencer #(
        .MUTSEL_W (8), .SIG_W (128), .WINDOW_W (16),
        .SETTLE_CYCLES (2), .EARLY_EXIT (0)
    ) dut_b (
        .clk_i (clk), .rst_i (rst), .start_i (start), .abort_i (abort),
        .first_idx_i (first), .last_idx_i (last), .window_i (window),
        .cmp_valid_i (cmp_valid), .sig_golden_i (sig_gold), .sig_mutant_i (sig_mut),
        .mutsel_o (mutsel_b), .busy_o (busy_b), .done_o (done_b),
        .result_valid_o (rv_b), .result_ready_i (ready),
        .result_idx_o (ridx_b), .result_detected_o (rdet_b),
        .result_cycles_o (rcyc_b), .detect_count_o (dcnt_b)
    );

    // Result handshakes and done pulses, stamped with the cycle number
    always @(negedge clk) begin
        if (rv_a && ready) qa.push_back('{ridx_a, rdet_a, rcyc_a, cyc});
        if (rv_b && ready) qb.push_back('{ridx_b, rdet_b, rcyc_b, cyc});
        if (done_a) da.push_back(cyc);
        if (done_b) db.push_back(cyc);
    end

    task automatic check_vec(input string tag, input logic [63:0] got,
                             input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        qa.delete(); qb.delete(); da.delete(); db.delete();
        start = 1'b0; abort = 1'b0; ready = 1'b1; cmp_valid = 1'b1;
        sig_mut = sig_gold;
        for (int i = 0; i < 3; i++) tick();
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; first = '0; last = '0;
        window = '0; cmp_valid = 1'b0; sig_gold = GOLD; sig_mut = GOLD;
        ready = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        check_vec("rst_mutsel", mutsel_a, 0);
        check_vec("rst_busy", busy_a, 0);
        check_vec("rst_done", done_a, 0);
        check_vec("rst_rvalid", rv_a, 0);
        check_vec("rst_ridx", ridx_a, 0);
        check_vec("rst_rdet", rdet_a, 0);
        check_vec("rst_rcyc", rcyc_a, 0);
        check_vec("rst_dcnt", dcnt_a, 0);
        rst = 1'b0;
        clear_logs();

        // Range 1..3, window 8; mutant 2 mismatches on its 3rd valid cycle (c18)
        first = 8'd1; last = 8'd3; window = 16'd8;
        for (int c = 0; c < 42; c++) begin
            if (c == 0) base = cyc;
            start   = (c == 0);
            sig_mut = (c == 18) ? (sig_gold ^ FLIP) : sig_gold;
            tick();
        end
        check_vec("t1_a_nres", qa.size(), 3);
        if (qa.size() == 3) begin
            check_vec("t1_a_r0", {qa[0].idx, 7'd0, qa[0].det, qa[0].cyc}, {8'd1, 8'd0, 16'd8});
            check_vec("t1_a_r1", {qa[1].idx, 7'd0, qa[1].det, qa[1].cyc}, {8'd2, 8'd1, 16'd3});
            check_vec("t1_a_r2", {qa[2].idx, 7'd0, qa[2].det, qa[2].cyc}, {8'd3, 8'd0, 16'd8});
            check_vec("t1_a_r1_at", qa[1].at, base + 19);
            check_vec("t1_a_r2_at", qa[2].at, base + 31);
        end
        check_vec("t1_a_ndone", da.size(), 1);
        if (da.size() == 1) check_vec("t1_a_done_at", da[0], base + 32);
        check_vec("t1_a_dcnt", dcnt_a, 1);
        check_vec("t1_a_mutsel", mutsel_a, 0);
        check_vec("t1_a_busy", busy_a, 0);
        check_vec("t1_b_nres", qb.size(), 3);
        if (qb.size() == 3) begin
            check_vec("t1_b_r1", {qb[1].idx, 7'd0, qb[1].det, qb[1].cyc}, {8'd2, 8'd1, 16'd8});
            check_vec("t1_b_r1_at", qb[1].at, base + 24);
        end
        if (db.size() == 1) check_vec("t1_b_done_at", db[0], base + 37);
        else check_vec("t1_b_ndone", db.size(), 1);
        clear_logs();

        // Toggling valid, window 4; mismatches only in SETTLE and invalid cycles
        first = 8'd1; last = 8'd1; window = 16'd4;
        for (int c = 0; c < 16; c++) begin
            if (c == 0) base = cyc;
            start     = (c == 0);
            cmp_valid = (c < 4) ? 1'b1 : ((c % 2) == 1);
            sig_mut   = ((c == 2) || (c == 3) || !cmp_valid) ? (sig_gold ^ FLIP) : sig_gold;
            tick();
        end
        check_vec("t3_nres", qa.size(), 1);
        if (qa.size() == 1) begin
            check_vec("t3_res", {qa[0].idx, 7'd0, qa[0].det, qa[0].cyc}, {8'd1, 8'd0, 16'd4});
            check_vec("t3_res_at", qa[0].at, base + 12);
        end
        clear_logs();

        // Backpressure: ready low for REPORT cycles 5..9, handshake at c10
        first = 8'd5; last = 8'd5; window = 16'd2;
        for (int c = 0; c < 14; c++) begin
            if (c == 5 || c == 9) begin
                check_vec("t4_rvalid", rv_a, 1);
                check_vec("t4_res", {ridx_a, 7'd0, rdet_a, rcyc_a}, {8'd5, 8'd1, 16'd1});
                check_vec("t4_mutsel", mutsel_a, 5);
                check_vec("t4_dcnt_hold", dcnt_a, 0);
            end
            if (c == 10) check_vec("t4_dcnt_hs", dcnt_a, 0);
            if (c == 11) begin
                check_vec("t4_dcnt_after", dcnt_a, 1);
                check_vec("t4_done", done_a, 1);
            end
            if (c == 0) base = cyc;
            start   = (c == 0);
            ready   = !((c >= 5) && (c <= 9));
            sig_mut = (c == 4) ? (sig_gold ^ FLIP) : sig_gold;
            tick();
        end
        check_vec("t4_nres", qa.size(), 1);
        clear_logs();

        // Abort (with a simultaneous start) during RUN of mutant 2
        first = 8'd1; last = 8'd5; window = 16'd8;
        for (int c = 0; c < 22; c++) begin
            if (c == 18) begin
                check_vec("t5_done", done_a, 1);
                check_vec("t5_busy_fin", busy_a, 0);
                check_vec("t5_rvalid", rv_a, 0);
            end
            if (c == 19) begin
                check_vec("t5_mutsel", mutsel_a, 0);
                check_vec("t5_done_low", done_a, 0);
            end
            if (c == 20) check_vec("t5_busy_idle", busy_a, 0);
            if (c == 0) base = cyc;
            start = (c == 0) || (c == 17);
            abort = (c == 17);
            tick();
        end
        check_vec("t5_nres", qa.size(), 1);
        if (qa.size() == 1) check_vec("t5_res_idx", qa[0].idx, 1);
        check_vec("t5_ndone", da.size(), 1);
        clear_logs();

        // Top index 255: single result, no wrap
        first = 8'd255; last = 8'd255; window = 16'd3;
        for (int c = 0; c < 12; c++) begin
            if (c == 9) check_vec("t6_mutsel", mutsel_a, 0);
            if (c == 0) base = cyc;
            start = (c == 0);
            tick();
        end
        check_vec("t6_nres", qa.size(), 1);
        if (qa.size() == 1) begin
            check_vec("t6_res", {qa[0].idx, 7'd0, qa[0].det, qa[0].cyc}, {8'd255, 8'd0, 16'd3});
            check_vec("t6_res_at", qa[0].at, base + 7);
        end
        check_vec("t6_ndone", da.size(), 1);
        if (da.size() == 1) check_vec("t6_done_at", da[0], base + 8);
        clear_logs();

        // Rejected ranges: first>last, first==0, window==0
        for (int k = 0; k < 3; k++) begin
            first  = (k == 0) ? 8'd4 : ((k == 1) ? 8'd0 : 8'd1);
            last   = (k == 0) ? 8'd2 : 8'd3;
            window = (k == 2) ? 16'd0 : 16'd8;
            da.delete();
            for (int c = 0; c < 5; c++) begin
                if (c == 1) check_vec("t7_done", done_a, 1);
                if (c == 2) check_vec("t7_busy", busy_a, 0);
                if (c == 0) base = cyc;
                start = (c == 0);
                tick();
            end
            if (da.size() == 1) check_vec("t7_done_at", da[0], base + 1);
            else check_vec("t7_ndone", da.size(), 1);
        end
        check_vec("t7_nres", qa.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
